// File: rtl/req_master_pkg.sv
// Shared constants and the per-channel state encoding for the req_master burst requester.
package req_master_pkg;

  localparam int unsigned NCH_DEF     = 4;
  localparam int unsigned BEAT_W_DEF  = 4;
  localparam int unsigned TMO_CYC_DEF = 200;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_REL  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    XFER = ST_XFER,
    REL  = ST_REL
  } ch_state_e;

endpackage

// File: rtl/req_master_if.sv
// Handshake bundle between req_master (master side) and its launcher/resolver (slave side).
interface req_master_if
  import req_master_pkg::*;
#(
  parameter int unsigned NCH    = NCH_DEF,
  parameter int unsigned BEAT_W = BEAT_W_DEF
) ();

  logic [NCH-1:0]        start;
  logic [NCH*BEAT_W-1:0] len;
  logic [NCH-1:0]        gnt;
  logic [NCH-1:0]        req;
  logic                  pr_en;
  logic [NCH-1:0]        beat;
  logic [NCH-1:0]        done;
  logic                  busy;
  logic [NCH-1:0]        tmo_err;

  modport master (
    input  start, len, gnt,
    output req, pr_en, beat, done, busy, tmo_err
  );

  modport slave (
    output start, len, gnt,
    input  req, pr_en, beat, done, busy, tmo_err
  );

endinterface

// File: rtl/req_master_ch.sv
// One burst-request channel: IDLE -> REQ -> XFER -> REL, with beat counter.
// Optional grant-wait timeout enabled by REQ_MASTER_TIMEOUT_EN.
module req_master_ch
  import req_master_pkg::*;
#(
  parameter int unsigned BEAT_W  = BEAT_W_DEF,
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [BEAT_W-1:0] len_i,
  input  logic              gnt_i,
  output logic              req_o,
  output logic              req_d_o,
  output logic              beat_o,
  output logic              done_o,
  output logic              xfer_o,
  output logic              tmo_err_o
);

  ch_state_e         state_q, state_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              beat_q, beat_d;
  logic              done_q, done_d;

`ifdef REQ_MASTER_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = 1'b0;
    done_d  = 1'b0;
`ifdef REQ_MASTER_TIMEOUT_EN
    wait_d  = wait_q;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = REQ;
          cnt_d   = (len_i == '0) ? BEAT_W'(1) : len_i;
`ifdef REQ_MASTER_TIMEOUT_EN
          wait_d  = '0;
          tmo_d   = 1'b0;
`endif
        end
      end
      REQ: begin
        if (gnt_i) state_d = XFER;
`ifdef REQ_MASTER_TIMEOUT_EN
        else if (wait_q == WAIT_W'(TMO_CYC - 1)) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end
        else wait_d = wait_q + 1'b1;
`endif
      end
      XFER: begin
        if (gnt_i) begin
          beat_d = 1'b1;
          // last beat: leave the counter at 1 rather than wrapping
          if (cnt_q == BEAT_W'(1)) begin
            state_d = REL;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ) || (state_d == XFER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      beat_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REQ_MASTER_TIMEOUT_EN
      wait_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
`ifdef REQ_MASTER_TIMEOUT_EN
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign req_o   = req_q;
  assign req_d_o = req_d;
  assign beat_o  = beat_q;
  assign done_o  = done_q;
  assign xfer_o  = (state_q == XFER);

`ifdef REQ_MASTER_TIMEOUT_EN
  assign tmo_err_o = tmo_q;
`else
  assign tmo_err_o = 1'b0;
`endif

endmodule

// File: rtl/req_master.sv
// Multi-channel burst requester: NCH independent channels feeding a priority resolver.
// Grant-wait timeout is built only when REQ_MASTER_TIMEOUT_EN is defined.
module req_master
  import req_master_pkg::*;
#(
  parameter int unsigned NCH     = NCH_DEF,
  parameter int unsigned BEAT_W  = BEAT_W_DEF,
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input logic         clk,
  input logic         rst,
  req_master_if.master bus
);

  logic [NCH-1:0] req_v, req_d_v, beat_v, done_v, xfer_v, tmo_v;
  logic           pr_en_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    req_master_ch #(
      .BEAT_W  (BEAT_W),
      .TMO_CYC (TMO_CYC)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .start_i   (bus.start[i]),
      .len_i     (bus.len[i*BEAT_W +: BEAT_W]),
      .gnt_i     (bus.gnt[i]),
      .req_o     (req_v[i]),
      .req_d_o   (req_d_v[i]),
      .beat_o    (beat_v[i]),
      .done_o    (done_v[i]),
      .xfer_o    (xfer_v[i]),
      .tmo_err_o (tmo_v[i])
    );
  end

  // registered alongside req so pr_en tracks the req lines cycle for cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pr_en_q <= 1'b0;
    else      pr_en_q <= |req_d_v;
  end

  assign bus.req     = req_v;
  assign bus.pr_en   = pr_en_q;
  assign bus.beat    = beat_v;
  assign bus.done    = done_v;
  assign bus.busy    = |xfer_v;
  assign bus.tmo_err = tmo_v;

endmodule

// File: tb/tb_req_master.sv
// Scoreboard bench for req_master: expected beat/done events are queued by the stimulus
// and popped by an independent monitor whenever the DUT shows a beat or done.
module tb_req_master;
  import req_master_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  req_master_if #(.NCH(4), .BEAT_W(4)) bus ();

  req_master #(.NCH(4), .BEAT_W(4), .TMO_CYC(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // fixed-priority resolver model (lowest index wins) or manual grant
  logic       auto_gnt;
  logic [3:0] gnt_man;
  always_comb bus.gnt = auto_gnt ? (bus.req & (~bus.req + 4'd1)) : gnt_man;

  typedef struct packed {
    logic [3:0] beat;
    logic [3:0] done;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  function automatic ev_t ev(input logic [3:0] b, input logic [3:0] d);
    return ev_t'({b, d});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] g, input logic [3:0] s);
    gnt_man   = g;
    bus.start = s;
    @(negedge clk);
    bus.start = '0;
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst && ((|bus.beat) || (|bus.done))) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", {24'h0, bus.beat, bus.done}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_event", {24'h0, bus.beat, bus.done}, {24'h0, e});
      end
    end
  end

  initial begin
    rst       = 1'b0;
    auto_gnt  = 1'b0;
    gnt_man   = '0;
    bus.start = '0;
    bus.len   = '0;
    repeat (2) @(negedge clk);
    chk("rst_req",   bus.req, 0);
    chk("rst_pr_en", bus.pr_en, 0);
    chk("rst_beat",  bus.beat, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_tmo",   bus.tmo_err, 0);
    rst = 1'b1;

    // ch0, len 3, start on first edge after release
    bus.len = 16'h0003;
    exp_q.push_back(ev(4'b0001, 4'b0000));
    exp_q.push_back(ev(4'b0001, 4'b0000));
    exp_q.push_back(ev(4'b0001, 4'b0001));
    step(4'b0000, 4'b0001);
    chk("t1_req_up", bus.req, 4'b0001);
    chk("t1_pr_en",  bus.pr_en, 1);
    step(4'b0001, 4'b0000);
    chk("t1_busy", bus.busy, 1);
    repeat (3) step(4'b0001, 4'b0000);
    chk("t1_req_rel", bus.req, 0);
    chk("t1_done",    bus.done, 4'b0001);
    step(4'b0000, 4'b0000);
    chk("t1_idle_busy", bus.busy, 0);
    chk("t1_done_once", bus.done, 0);
    chk("t1_pr_en_off", bus.pr_en, 0);

    // ch2, len 4, two-cycle grant stall after beat 2
    bus.len = 16'h0400;
    repeat (3) exp_q.push_back(ev(4'b0100, 4'b0000));
    exp_q.push_back(ev(4'b0100, 4'b0100));
    step(4'b0000, 4'b0100);
    repeat (3) step(4'b0100, 4'b0000);
    step(4'b0000, 4'b0000);
    chk("t2_stall_req",  bus.req, 4'b0100);
    chk("t2_stall_beat", bus.beat, 0);
    step(4'b0000, 4'b0000);
    chk("t2_stall_req2", bus.req, 4'b0100);
    chk("t2_stall_busy", bus.busy, 1);
    repeat (2) step(4'b0100, 4'b0000);
    chk("t2_req_rel", bus.req, 0);
    step(4'b0000, 4'b0000);

    // all four channels, len 1, fixed-priority resolver
    bus.len  = 16'h1111;
    auto_gnt = 1'b1;
    exp_q.push_back(ev(4'b0001, 4'b0001));
    exp_q.push_back(ev(4'b0010, 4'b0010));
    exp_q.push_back(ev(4'b0100, 4'b0100));
    exp_q.push_back(ev(4'b1000, 4'b1000));
    step(4'b0000, 4'b1111);
    chk("t3_req_all", bus.req, 4'b1111);
    repeat (7) step(4'b0000, 4'b0000);
    chk("t3_pr_en_last", bus.pr_en, 1);
    chk("t3_req_last",   bus.req, 4'b1000);
    step(4'b0000, 4'b0000);
    chk("t3_pr_en_fall", bus.pr_en, 0);
    chk("t3_req_none",   bus.req, 0);
    auto_gnt = 1'b0;
    step(4'b0000, 4'b0000);
    chk("t3_busy", bus.busy, 0);

    // multi-bit grant, len 0 counts as one beat, grant ignored in REL/IDLE
    bus.len = 16'h0002;
    exp_q.push_back(ev(4'b0011, 4'b0010));
    exp_q.push_back(ev(4'b0001, 4'b0001));
    step(4'b0000, 4'b0011);
    repeat (4) step(4'b0011, 4'b0000);
    chk("t4_req_idle",  bus.req, 0);
    chk("t4_busy_idle", bus.busy, 0);
    step(4'b0000, 4'b0000);

    // ch3 waiting for a grant that never comes
    bus.len = 16'h1000;
    step(4'b0000, 4'b1000);
    chk("t5_req_up", bus.req, 4'b1000);
`ifdef REQ_MASTER_TIMEOUT_EN
    repeat (9) step(4'b0000, 4'b0000);
    chk("t5_tmo_before", bus.tmo_err, 0);
    chk("t5_req_before", bus.req, 4'b1000);
    step(4'b0000, 4'b0000);
    chk("t5_tmo_set",  bus.tmo_err, 4'b1000);
    chk("t5_req_drop", bus.req, 0);
    repeat (3) step(4'b0000, 4'b0000);
    chk("t5_tmo_sticky", bus.tmo_err, 4'b1000);
    exp_q.push_back(ev(4'b1000, 4'b1000));
    step(4'b0000, 4'b1000);
    chk("t5_tmo_clear", bus.tmo_err, 0);
    chk("t5_req_again", bus.req, 4'b1000);
`else
    repeat (30) step(4'b0000, 4'b0000);
    chk("t5_req_wait", bus.req, 4'b1000);
    chk("t5_tmo_zero", bus.tmo_err, 0);
    exp_q.push_back(ev(4'b1000, 4'b1000));
`endif
    repeat (2) step(4'b1000, 4'b0000);
    chk("t5_req_rel", bus.req, 0);
    step(4'b0000, 4'b0000);

    // start during XFER must not reload the burst
    bus.len = 16'h0003;
    repeat (2) exp_q.push_back(ev(4'b0001, 4'b0000));
    exp_q.push_back(ev(4'b0001, 4'b0001));
    step(4'b0000, 4'b0001);
    step(4'b0001, 4'b0000);
    bus.len = 16'h000F;
    step(4'b0001, 4'b0001);
    repeat (2) step(4'b0001, 4'b0000);
    chk("t6_req_rel", bus.req, 0);
    step(4'b0000, 4'b0000);
    chk("t6_busy", bus.busy, 0);
    chk("t6_req",  bus.req, 0);

    // reset mid-burst on ch1 after 3 of 8 beats
    bus.len = 16'h0080;
    repeat (3) exp_q.push_back(ev(4'b0010, 4'b0000));
    step(4'b0000, 4'b0010);
    repeat (4) step(4'b0010, 4'b0000);
    #1 rst = 1'b0;
    #1;
    chk("t7_async_req",   bus.req, 0);
    chk("t7_async_pr_en", bus.pr_en, 0);
    chk("t7_async_beat",  bus.beat, 0);
    chk("t7_async_done",  bus.done, 0);
    chk("t7_async_busy",  bus.busy, 0);
    chk("t7_async_tmo",   bus.tmo_err, 0);
    gnt_man = '0;
    @(negedge clk);
    @(negedge clk);
    chk("t7_hold_req", bus.req, 0);
    rst     = 1'b1;
    bus.len = 16'h0020;
    exp_q.push_back(ev(4'b0010, 4'b0000));
    exp_q.push_back(ev(4'b0010, 4'b0010));
    step(4'b0000, 4'b0010);
    chk("t7_req_up", bus.req, 4'b0010);
    repeat (3) step(4'b0010, 4'b0000);
    chk("t7_req_rel", bus.req, 0);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/req_master.md
REQ_MASTER -- requirements
Module: req_master

Interface
REQ-001 Parameter NCH, default 4: number of requesting channels; one req/gnt pair each.
REQ-002 Parameter BEAT_W, default 4: width of the per-channel burst-length field.
REQ-003 Parameter TMO_CYC, default 200: grant-wait timeout in clk cycles.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  NCH  per-channel one-cycle pulse that launches a burst.
REQ-007 len  input  NCH*BEAT_W  per-channel burst length, sampled with start; channel i uses slice [i*BEAT_W +: BEAT_W].
REQ-008 gnt  input  NCH  one-hot grant from the priority resolver.
REQ-009 req  output  NCH  registered request lines to the priority resolver.
REQ-010 pr_en  output  1  registered resolver enable: high while any req bit is high.
REQ-011 beat  output  NCH  registered beat strobe: high in a cycle where channel i transfers one beat.
REQ-012 done  output  NCH  registered one-cycle pulse when channel i completes its burst.
REQ-013 busy  output  1  combinational OR of all channels in state XFER.
REQ-014 tmo_err  output  NCH  sticky timeout flag per channel.

Function
REQ-015 Each channel runs an independent FSM with states IDLE, REQ, XFER and REL.
REQ-016 IDLE: on start[i], the channel latches len_i, counter = len_i, moves to REQ, and drives req[i]=1 next cycle; start in any other state is ignored.
REQ-017 len_i = 0 is treated as 1 beat.
REQ-018 REQ: req[i] held high; when gnt[i]=1 is sampled, the channel moves to XFER.
REQ-019 XFER: each cycle with gnt[i]=1, beat[i]=1 and counter decrements; a cycle with gnt[i]=0 stalls with beat[i]=0, counter held, and req[i] kept high.
REQ-020 When a beat occurs with counter = 1, next state is REL and done[i] pulses on the same edge that enters REL.
REQ-021 REL: req[i]=0 for exactly one cycle, then IDLE; a new start is accepted only in IDLE.
REQ-022 Counter arithmetic is BEAT_W bits unsigned and never wraps below 1 in XFER.
REQ-023 pr_en = OR of next-state req bits, registered with req.
REQ-024 gnt with more than one bit set: every channel with its own gnt bit set acts on it independently; no error is flagged.
REQ-025 gnt[i]=1 while channel i is in IDLE or REL is ignored.
REQ-026 Simultaneous start on several channels: all enter REQ together; ordering is left to the resolver.

Reset
REQ-027 Assertion of rst (low) forces every channel FSM to IDLE immediately, mid-burst included, and clears counters.
REQ-028 Reset values: req=0, pr_en=0, beat=0, done=0, tmo_err=0; busy=0 follows from all channels being in IDLE.
REQ-029 Deassertion is synchronous to clk; the first start is accepted on the first rising edge after release.

Configuration
REQ-030 Macro REQ_MASTER_TIMEOUT_EN: when defined, a per-channel wait counter runs in REQ and resets on entering REQ.
REQ-031 With REQ_MASTER_TIMEOUT_EN, reaching TMO_CYC cycles in REQ without gnt[i] sets tmo_err[i], drops req[i] and returns the channel to IDLE with no done pulse.
REQ-032 Once set, tmo_err[i] clears only on reset or on the next accepted start[i].
REQ-033 Without the macro, no wait counter exists, tmo_err is tied to 0, and REQ waits indefinitely.

Structure
REQ-034 Package req_master_pkg holds the channel state enum (IDLE, REQ, XFER, REL) and default constants for NCH, BEAT_W and TMO_CYC.
REQ-035 Sub-module req_master_ch implements one channel FSM and its counters; req_master instantiates it NCH times with a generate loop and builds pr_en and busy.

Verification
REQ-036 Reset, then start[0] with len0=3, gnt=0001 one cycle after req[0] rises -> beat[0] high 3 cycles, done[0] one pulse, req[0] low for 1 cycle, channel back in IDLE.
REQ-037 Channel 2 in XFER with len=4, gnt[2] dropped for 2 cycles after beat 2 -> beat[2] low 2 cycles, req[2] stays high, total beats = 4, single done[2].
REQ-038 start=1111 with len=1 each, resolver in fixed priority -> grants served in order 0,1,2,3; each channel gives 1 beat and 1 done; pr_en falls after the last REL.
REQ-039 With REQ_MASTER_TIMEOUT_EN and TMO_CYC=10: start[3], gnt held 0000 -> tmo_err[3]=1 after 10 cycles in REQ, req[3]=0, no done; a new start[3] clears tmo_err[3].
REQ-040 rst pulsed low mid-XFER on channel 1 (len=8, after 3 beats) -> all outputs 0 immediately; after release, start[1] with len=2 yields exactly 2 beats.
REQ-041 start[0] pulsed while channel 0 is in XFER -> pulse ignored; the burst completes with its original len and only one done[0].
